// File: rtl/vec_pkg.sv
// Shared opcodes, flag bit positions and sequencer state encoding for the vector execute stage.
package vec_pkg;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SET = 3'b111;

  localparam int unsigned FLG_V = 3;
  localparam int unsigned FLG_N = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_state_t;

endpackage

// File: rtl/ALU_vec_aux.sv
// Single-lane signed ALU: mul/sub/add/set with two's-complement wrap and {V,N,0,0} flags.
module ALU_vec_aux
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       opcode,
  input  logic             flag_scalar,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [7:0]       instance_num,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic               ovf;
  logic               unused_inst;

  assign unused_inst = ^instance_num;

  // flag_scalar substitutes the broadcast scalar for operand B
  assign opb  = flag_scalar ? data_c : data_b;
  assign sum  = {data_a[WIDTH-1], data_a} + {opb[WIDTH-1], opb};
  assign diff = {data_a[WIDTH-1], data_a} - {opb[WIDTH-1], opb};
  assign prod = $signed({{WIDTH{data_a[WIDTH-1]}}, data_a}) *
                $signed({{WIDTH{opb[WIDTH-1]}}, opb});

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        ovf    = sum[WIDTH] ^ sum[WIDTH-1];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        ovf    = diff[WIDTH] ^ diff[WIDTH-1];
      end
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        ovf    = prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]};
      end
      OP_SET: result = data_c;
      default: ;
    endcase
  end

  always_comb begin
    flags        = 4'b0000;
    flags[FLG_V] = ovf;
    flags[FLG_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Vector execute stage: streams LANES elements through ALUS ALUs, ALUS lanes per cycle.
module vec_alu_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 16,
  parameter int unsigned ALUS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             opcode,
  input  logic                   flag_scalar,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0]       scalar_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] vec_result,
  output logic [LANES*4-1:0]     lane_flags,
  output logic [3:0]             flags_any,
  output logic [3:0]             flags_all
);

  localparam int unsigned G  = LANES / ALUS;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

  if (LANES % ALUS != 0) begin : g_bad_lanes
    $error("LANES must be a multiple of ALUS");
  end

  seq_state_t             state_q;
  logic [GW-1:0]          grp_q;
  logic [2:0]             op_q;
  logic                   fs_q;
  logic [LANES*WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]       c_q;
  logic [ALUS*WIDTH-1:0]  alu_res;
  logic [ALUS*4-1:0]      alu_flg;
  logic                   accept;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  for (genvar k = 0; k < ALUS; k++) begin : g_alu
    logic [7:0] lane;
    assign lane = 8'(int'(grp_q) * ALUS + k);
    ALU_vec_aux #(.WIDTH(WIDTH)) u_alu (
      .opcode      (op_q),
      .flag_scalar (fs_q),
      .data_a      (a_q[lane*WIDTH +: WIDTH]),
      .data_b      (b_q[lane*WIDTH +: WIDTH]),
      .data_c      (c_q),
      .instance_num(lane),
      .result      (alu_res[k*WIDTH +: WIDTH]),
      .flags       (alu_flg[k*4 +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      op_q       <= '0;
      fs_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      vec_result <= '0;
      lane_flags <= '0;
    end else begin
      if (accept) begin
        op_q    <= opcode;
        fs_q    <= flag_scalar;
        a_q     <= vec_a;
        b_q     <= vec_b;
        c_q     <= scalar_c;
        grp_q   <= '0;
        state_q <= BUSY;
      end else begin
        case (state_q)
          BUSY: begin
            for (int k = 0; k < ALUS; k++) begin
              vec_result[(int'(grp_q) * ALUS + k) * WIDTH +: WIDTH] <= alu_res[k*WIDTH +: WIDTH];
              lane_flags[(int'(grp_q) * ALUS + k) * 4 +: 4]         <= alu_flg[k*4 +: 4];
            end
            if (grp_q == GW'(G - 1)) state_q <= DONE;
            else                     grp_q   <= grp_q + GW'(1);
          end
          DONE:    if (out_ready) state_q <= IDLE;
          IDLE:    ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    flags_any = 4'b0000;
    flags_all = 4'b1111;
    for (int i = 0; i < LANES; i++) begin
      flags_any = flags_any | lane_flags[i*4 +: 4];
      flags_all = flags_all & lane_flags[i*4 +: 4];
    end
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer: vector table plus backpressure, reset-abort and G=1 cases.
module tb_vec_alu_sequencer;

  localparam int W = 8;
  localparam int L = 16;

  typedef struct {
    logic [2:0]     op;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [W-1:0]   c;
    logic [L*W-1:0] er;
    logic [L*4-1:0] ef;
    logic [3:0]     eany;
    logic [3:0]     eall;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, flag_scalar, out_valid, out_ready;
  logic [2:0]     opcode;
  logic [L*W-1:0] vec_a, vec_b, vec_result;
  logic [W-1:0]   scalar_c;
  logic [L*4-1:0] lane_flags;
  logic [3:0]     flags_any, flags_all;

  logic           in_valid1, in_ready1, out_valid1, out_ready1;
  logic [2:0]     opcode1;
  logic [L*W-1:0] vec_a1, vec_b1, vec_result1;
  logic [L*4-1:0] lane_flags1;
  logic [3:0]     flags_any1, flags_all1;

  int checks = 0;
  int errors = 0;
  vec_t tv[6];

  always #5 clk = ~clk;

  vec_alu_sequencer #(.WIDTH(W), .LANES(L), .ALUS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .flag_scalar(flag_scalar), .vec_a(vec_a), .vec_b(vec_b), .scalar_c(scalar_c),
    .out_valid(out_valid), .out_ready(out_ready), .vec_result(vec_result),
    .lane_flags(lane_flags), .flags_any(flags_any), .flags_all(flags_all)
  );

  vec_alu_sequencer #(.WIDTH(W), .LANES(L), .ALUS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .opcode(opcode1),
    .flag_scalar(1'b0), .vec_a(vec_a1), .vec_b(vec_b1), .scalar_c(8'd0),
    .out_valid(out_valid1), .out_ready(out_ready1), .vec_result(vec_result1),
    .lane_flags(lane_flags1), .flags_any(flags_any1), .flags_all(flags_all1)
  );

  function automatic logic [L*W-1:0] rep8(input logic [7:0] v);
    logic [L*W-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [L*4-1:0] rep4(input logic [3:0] f);
    logic [L*4-1:0] r;
    for (int i = 0; i < L; i++) r[i*4 +: 4] = f;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one op on the 4-ALU instance and return edges from accept to out_valid
  task automatic do_op(input vec_t v, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    opcode = v.op; vec_a = v.a; vec_b = v.b; scalar_c = v.c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, " result"}, vec_result, v.er);
    chk({nm, " lane_flags"}, {64'd0, lane_flags}, {64'd0, v.ef});
    chk({nm, " flags_any"}, {124'd0, flags_any}, {124'd0, v.eany});
    chk({nm, " flags_all"}, {124'd0, flags_all}, {124'd0, v.eall});
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    tv[0] = '{op: 3'b010, a: rep8(8'd50), b: rep8(8'd25), c: 8'd0, er: rep8(8'd75),
              ef: '0, eany: 4'b0000, eall: 4'b0000};
    tv[1] = '{op: 3'b010, a: rep8(8'd1), b: rep8(8'd1), c: 8'd0, er: rep8(8'd2),
              ef: '0, eany: 4'b1100, eall: 4'b0000};
    tv[1].a[31:24] = 8'd100; tv[1].b[31:24] = 8'd50; tv[1].er[31:24] = 8'h96;
    tv[1].ef[15:12] = 4'b1100;
    tv[2] = '{op: 3'b000, a: rep8(8'hEC), b: rep8(8'd3), c: 8'd0, er: rep8(8'hC4),
              ef: rep4(4'b0100), eany: 4'b0100, eall: 4'b0100};
    tv[3] = '{op: 3'b111, a: rep8(8'd9), b: rep8(8'd7), c: 8'hCE, er: rep8(8'hCE),
              ef: rep4(4'b0100), eany: 4'b0100, eall: 4'b0100};
    tv[4] = '{op: 3'b001, a: rep8(8'd25), b: rep8(8'd50), c: 8'd0, er: rep8(8'hE7),
              ef: rep4(4'b0100), eany: 4'b0100, eall: 4'b0100};
    tv[5] = '{op: 3'b001, a: rep8(8'h80), b: rep8(8'd1), c: 8'd0, er: rep8(8'h7F),
              ef: rep4(4'b1000), eany: 4'b1000, eall: 4'b1000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; flag_scalar = 1'b0;
    vec_a = '0; vec_b = '0; scalar_c = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; opcode1 = '0; vec_a1 = '0; vec_b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {127'd0, out_valid}, '0);
    chk("reset in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset vec_result", vec_result, '0);
    chk("reset lane_flags", {64'd0, lane_flags}, '0);
    chk("reset flags_any", {124'd0, flags_any}, '0);
    chk("reset flags_all", {124'd0, flags_all}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op(tv[i], lat);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
      chk_result($sformatf("vec%0d", i), tv[i]);
      release_out();
    end

    // Backpressure, then back-to-back accept in the DONE/out_ready cycle
    do_op(tv[0], lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d vec_result", i), vec_result, tv[0].er);
      chk($sformatf("hold%0d in_ready", i), {127'd0, in_ready}, '0);
      chk($sformatf("hold%0d out_valid", i), {127'd0, out_valid}, 128'd1);
    end
    opcode = tv[2].op; vec_a = tv[2].a; vec_b = tv[2].b; scalar_c = tv[2].c;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b busy out_valid", {127'd0, out_valid}, '0);
    chk("b2b busy in_ready", {127'd0, in_ready}, '0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("b2b latency", 128'(lat), 128'd4);
    chk_result("b2b", tv[2]);
    release_out();

    // Reset while BUSY with grp==2
    opcode = tv[3].op; vec_a = tv[3].a; vec_b = tv[3].b; scalar_c = tv[3].c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", {127'd0, out_valid}, '0);
    chk("abort in_ready", {127'd0, in_ready}, 128'd1);
    chk("abort vec_result", vec_result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-abort out_valid", {127'd0, out_valid}, '0);
    do_op(tv[1], lat);
    chk("post-abort latency", 128'(lat), 128'd4);
    chk_result("post-abort", tv[1]);
    release_out();

    // Single-group configuration
    opcode1 = 3'b001; vec_a1 = rep8(8'd25); vec_b1 = rep8(8'd50); in_valid1 = 1'b1;
    #1;
    chk("g1 in_ready", {127'd0, in_ready1}, 128'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("g1 latency", 128'(lat), 128'd1);
    chk("g1 result", vec_result1, rep8(8'hE7));
    chk("g1 flags_all", {124'd0, flags_all1}, 128'b0100);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("g1 idle out_valid", {127'd0, out_valid1}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
